key_search_controller: RTL and testbench

- Top-level sequencer for one RC4 brute-force core.
- For each candidate key it runs, in order, the S-array init FSM, the shuffle (KSA) FSM, the decrypt (PRGA) FSM and the plaintext checker FSM.
- It drives each sub-FSM through a Start/Finish/Finish_ack handshake and grants the shared S/D memory port to whichever sub-FSM is active.
- It steps the key through a configurable range and reports found, exhausted or aborted.

---
 rtl/key_search_controller.sv | 185 ++++++++++++++++++
 tb/tb_key_search_controller.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_search_controller.sv
// Top-level sequencer for one RC4 brute-force core: walks a key range and runs the
// init / shuffle / decrypt / checker sub-FSMs in turn for each candidate key.
module key_search_controller #(
    parameter int unsigned           KEY_WIDTH = 24,
    parameter logic [KEY_WIDTH-1:0]  KEY_START = '0,
    parameter logic [KEY_WIDTH-1:0]  KEY_END   = KEY_WIDTH'(24'h3FFFFF),
    parameter int unsigned           KEY_STEP  = 1
) (
    input  logic                 CLOCK_50,
    input  logic                 rst,
    input  logic                 search_start,
    input  logic                 search_clear,
    input  logic                 abort,
    output logic                 Init_Start,
    output logic                 Shuf_Start,
    output logic                 Dec_Start,
    output logic                 Checker_Start,
    input  logic                 Init_Finish,
    input  logic                 Shuf_Finish,
    input  logic                 Dec_Finish,
    input  logic                 Checker_Finish,
    input  logic                 Decrypt_Valid,
    output logic                 Finish_ack,
    output logic [1:0]           mem_sel,
    output logic [KEY_WIDTH-1:0] secret_key,
    output logic                 busy,
    output logic                 done,
    output logic                 key_found
);

    localparam logic [3:0] StIdle      = 4'd0;
    localparam logic [3:0] StLoad      = 4'd1;
    localparam logic [3:0] StInitRun   = 4'd2;
    localparam logic [3:0] StInitAck   = 4'd3;
    localparam logic [3:0] StShufRun   = 4'd4;
    localparam logic [3:0] StShufAck   = 4'd5;
    localparam logic [3:0] StDecRun    = 4'd6;
    localparam logic [3:0] StDecAck    = 4'd7;
    localparam logic [3:0] StChkRun    = 4'd8;
    localparam logic [3:0] StChkAck    = 4'd9;
    localparam logic [3:0] StNextKey   = 4'd10;
    localparam logic [3:0] StFound     = 4'd11;
    localparam logic [3:0] StExhausted = 4'd12;
    localparam logic [3:0] StAborted   = 4'd13;

    localparam logic [KEY_WIDTH:0] StepExt = (KEY_WIDTH + 1)'(KEY_STEP);

    logic [3:0]           state_q, state_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic                 valid_q, valid_d;
    logic [KEY_WIDTH:0]   key_sum;
    logic                 past_end;

    // One extra bit so a step past the top of the key space cannot wrap to 0.
    assign key_sum  = {1'b0, key_q} + StepExt;
    assign past_end = key_sum > {1'b0, KEY_END};

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        valid_d = valid_q;
        case (state_q)
            StIdle: begin
                if (search_start) state_d = StLoad;
            end
            StLoad: begin
                key_d   = KEY_START;
                valid_d = 1'b0;
                state_d = StInitRun;
            end
            StInitRun: begin
                if (Init_Finish) state_d = StInitAck;
            end
            StInitAck: state_d = StShufRun;
            StShufRun: begin
                if (Shuf_Finish) state_d = StShufAck;
            end
            StShufAck: state_d = StDecRun;
            StDecRun: begin
                if (Dec_Finish) state_d = StDecAck;
            end
            StDecAck: state_d = StChkRun;
            StChkRun: begin
                if (Checker_Finish) begin
                    valid_d = Decrypt_Valid;
                    state_d = StChkAck;
                end
            end
            StChkAck: begin
                state_d = valid_q ? StFound : StNextKey;
            end
            StNextKey: begin
                if (abort) begin
                    state_d = StAborted;
                end else if (past_end) begin
                    state_d = StExhausted;
                end else begin
                    key_d   = key_sum[KEY_WIDTH-1:0];
                    state_d = StInitRun;
                end
            end
            StFound, StExhausted, StAborted: begin
                if (search_clear) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            key_q   <= KEY_START;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            valid_q <= valid_d;
        end
    end

    // Outputs depend only on registered state so sub-FSMs never see input-driven glitches.
    always_comb begin
        Init_Start    = 1'b0;
        Shuf_Start    = 1'b0;
        Dec_Start     = 1'b0;
        Checker_Start = 1'b0;
        Finish_ack    = 1'b0;
        mem_sel       = 2'd0;
        busy          = 1'b0;
        done          = 1'b0;
        key_found     = 1'b0;
        case (state_q)
            StLoad, StNextKey: busy = 1'b1;
            StInitRun: begin
                busy       = 1'b1;
                Init_Start = 1'b1;
                mem_sel    = 2'd0;
            end
            StInitAck: begin
                busy       = 1'b1;
                Finish_ack = 1'b1;
                mem_sel    = 2'd0;
            end
            StShufRun: begin
                busy       = 1'b1;
                Shuf_Start = 1'b1;
                mem_sel    = 2'd1;
            end
            StShufAck: begin
                busy       = 1'b1;
                Finish_ack = 1'b1;
                mem_sel    = 2'd1;
            end
            StDecRun: begin
                busy      = 1'b1;
                Dec_Start = 1'b1;
                mem_sel   = 2'd2;
            end
            StDecAck: begin
                busy       = 1'b1;
                Finish_ack = 1'b1;
                mem_sel    = 2'd2;
            end
            StChkRun: begin
                busy          = 1'b1;
                Checker_Start = 1'b1;
                mem_sel       = 2'd3;
            end
            StChkAck: begin
                busy       = 1'b1;
                Finish_ack = 1'b1;
                mem_sel    = 2'd3;
            end
            StFound: begin
                done      = 1'b1;
                key_found = 1'b1;
            end
            StExhausted, StAborted: done = 1'b1;
            default: ;
        endcase
    end

    assign secret_key = key_q;

endmodule

// File: tb/tb_key_search_controller.sv
// Bench for key_search_controller: three cores with different key ranges, random-latency
// sub-FSM models, and a key-walk reference model.
module tb_key_search_controller;
    localparam int unsigned KW = 24;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic          rst_n;
    logic [2:0]    search_start, search_clear, abort, stray, good_en;
    logic [KW-1:0] good_key [3];

    wire [2:0]    busy_w, done_w, found_w, ack_w;
    wire [3:0]    start_w [3];
    wire [1:0]    sel_w [3];
    wire [KW-1:0] key_w [3];
    wire [31:0]   acks_w [3];
    wire [31:0]   viol_w [3];

    int checks   = 0;
    int failures = 0;
    int unsigned exp_keys [$];

    for (genvar g = 0; g < 3; g++) begin : g_core
        localparam logic [KW-1:0] KS  = (g == 1) ? 24'd1 : 24'd0;
        localparam logic [KW-1:0] KE  = (g == 0) ? 24'd3 : (g == 1) ? 24'd6 : 24'h3FFFFF;
        localparam int unsigned   KST = (g == 1) ? 2 : 1;

        logic [3:0]    st, fin, armed;
        logic [2:0]    cnt [4];
        logic          ack, dv;
        logic [1:0]    sel;
        logic [KW-1:0] key;
        int unsigned   keys [$];
        int            acks = 0;
        int            viol = 0;
        logic [3:0]    st_prev = '0;
        logic [1:0]    exp_sel = '0;

        assign dv = good_en[g] && (key == good_key[g]);

        key_search_controller #(
            .KEY_WIDTH(KW), .KEY_START(KS), .KEY_END(KE), .KEY_STEP(KST)
        ) u_dut (
            .CLOCK_50(clk), .rst(rst_n),
            .search_start(search_start[g]), .search_clear(search_clear[g]), .abort(abort[g]),
            .Init_Start(st[0]), .Shuf_Start(st[1]), .Dec_Start(st[2]), .Checker_Start(st[3]),
            .Init_Finish(fin[0]), .Shuf_Finish(fin[1]), .Dec_Finish(fin[2]),
            .Checker_Finish(fin[3] | stray[g]), .Decrypt_Valid(dv), .Finish_ack(ack),
            .mem_sel(sel), .secret_key(key), .busy(busy_w[g]), .done(done_w[g]),
            .key_found(found_w[g])
        );

        assign start_w[g] = st;
        assign sel_w[g]   = sel;
        assign key_w[g]   = key;
        assign ack_w[g]   = ack;
        assign acks_w[g]  = acks;
        assign viol_w[g]  = viol;

        // Sub-FSM models: Finish rises 2..5 cycles after Start and holds until acknowledged.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                fin   <= '0;
                armed <= '0;
                for (int s = 0; s < 4; s++) cnt[s] <= '0;
            end else begin
                for (int s = 0; s < 4; s++) begin
                    if (fin[s]) begin
                        if (ack) fin[s] <= 1'b0;
                    end else if (st[s]) begin
                        if (!armed[s]) begin
                            armed[s] <= 1'b1;
                            cnt[s]   <= 3'($urandom_range(0, 3));
                        end else if (cnt[s] == 3'd0) begin
                            fin[s]   <= 1'b1;
                            armed[s] <= 1'b0;
                        end else begin
                            cnt[s] <= cnt[s] - 3'd1;
                        end
                    end
                end
            end
        end

        // Handshake monitor: stage order, memory owner, single Start, ack only with no Start.
        always @(negedge clk) begin
            if (!rst_n) begin
                st_prev = '0;
                exp_sel = '0;
            end else begin
                if ((st & ~st_prev) != 4'b0000) begin
                    if ((st & ~st_prev) != (4'b0001 << exp_sel)) viol++;
                    if (sel != exp_sel) viol++;
                    if (st[0]) keys.push_back(32'(key));
                    exp_sel = exp_sel + 2'd1;
                end
                if ($countones(st) > 1) viol++;
                if (ack && st != 4'b0000) viol++;
                if (ack) acks++;
                st_prev = st;
            end
        end
    end

    function automatic int unsigned got_len(input int i);
        case (i)
            0:       return g_core[0].keys.size();
            1:       return g_core[1].keys.size();
            default: return g_core[2].keys.size();
        endcase
    endfunction

    function automatic int unsigned got_key(input int i, input int unsigned j);
        case (i)
            0:       return g_core[0].keys[j];
            1:       return g_core[1].keys[j];
            default: return g_core[2].keys[j];
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: walk the key range; outcome 1=found, 2=exhausted, 3=aborted.
    task automatic ref_search(input int unsigned ks, input int unsigned ke, input int unsigned step,
                              input bit ven, input int unsigned vkey, input bit ab_en,
                              input int unsigned ab_key, output int outcome,
                              output int unsigned last);
        longint unsigned k = ks;
        exp_keys.delete();
        forever begin
            exp_keys.push_back(32'(k));
            last = 32'(k);
            if (ven && k == vkey)    begin outcome = 1; break; end
            if (ab_en && k >= ab_key) begin outcome = 3; break; end
            if (k + step > ke)       begin outcome = 2; break; end
            k += step;
        end
    endtask

    task automatic pulse_start(input int i);
        @(negedge clk) search_start[i] = 1'b1;
        @(negedge clk) search_start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input string tag);
        int n = 0;
        while (!done_w[i] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(done_w[i]), 32'd1);
    endtask

    task automatic clear_core(input int i, input string tag);
        @(negedge clk) search_clear[i] = 1'b1;
        @(negedge clk) search_clear[i] = 1'b0;
        check({tag, "_clr_done"}, 32'(done_w[i]), 32'd0);
        check({tag, "_clr_busy"}, 32'(busy_w[i]), 32'd0);
    endtask

    task automatic check_result(input int i, input string tag, input int outcome,
                                input int unsigned last, input int unsigned n0,
                                input int unsigned a0);
        check({tag, "_found"}, 32'(found_w[i]), (outcome == 1) ? 32'd1 : 32'd0);
        check({tag, "_key"}, 32'(key_w[i]), last);
        check({tag, "_busy"}, 32'(busy_w[i]), 32'd0);
        check({tag, "_nkeys"}, got_len(i) - n0, exp_keys.size());
        for (int j = 0; j < exp_keys.size() && n0 + j < got_len(i); j++)
            check({tag, "_keyseq"}, got_key(i, n0 + j), exp_keys[j]);
        check({tag, "_acks"}, acks_w[i] - a0, 32'(4 * exp_keys.size()));
    endtask

    task automatic run_search(input int i, input string tag, input int unsigned ks,
                              input int unsigned ke, input int unsigned step, input bit ven,
                              input int unsigned vkey, input bit ab_en,
                              input int unsigned ab_key);
        int          outcome;
        int unsigned last, n0, a0;
        int          n;
        ref_search(ks, ke, step, ven, vkey, ab_en, ab_key, outcome, last);
        good_en[i]  = ven;
        good_key[i] = KW'(vkey);
        n0 = got_len(i);
        a0 = acks_w[i];
        pulse_start(i);
        if (ab_en) begin
            n = 0;
            while (!(start_w[i][2] && key_w[i] == KW'(ab_key)) && n < 3000) begin
                @(negedge clk);
                n++;
            end
            check({tag, "_reach_dec"}, 32'(start_w[i][2]), 32'd1);
            abort[i] = 1'b1;
        end
        wait_done(i, {tag, "_done"});
        check_result(i, tag, outcome, last, n0, a0);
        repeat (3) @(negedge clk);
        check({tag, "_frozen"}, 32'(key_w[i]), last);
        abort[i]   = 1'b0;
        good_en[i] = 1'b0;
        clear_core(i, tag);
    endtask

    initial begin
        int          n;
        int unsigned n0, a0;
        rst_n        = 1'b0;
        search_start = '0;
        search_clear = '0;
        abort        = '0;
        stray        = '0;
        good_en      = '0;
        for (int i = 0; i < 3; i++) good_key[i] = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_busy", 32'(busy_w[i]), 32'd0);
            check("rst_done", 32'(done_w[i]), 32'd0);
            check("rst_found", 32'(found_w[i]), 32'd0);
            check("rst_start", 32'(start_w[i]), 32'd0);
            check("rst_ack", 32'(ack_w[i]), 32'd0);
            check("rst_sel", 32'(sel_w[i]), 32'd0);
            check("rst_key", 32'(key_w[i]), (i == 1) ? 32'd1 : 32'd0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_search(2, "found", 0, 24'h3FFFFF, 1, 1'b1, 2, 1'b0, 0);
        run_search(2, "found_rnd", 0, 24'h3FFFFF, 1, 1'b1, $urandom_range(0, 6), 1'b0, 0);
        run_search(0, "exhaust", 0, 3, 1, 1'b0, 0, 1'b0, 0);
        run_search(0, "exh_rnd", 0, 3, 1, 1'b1, $urandom_range(0, 3), 1'b0, 0);
        run_search(1, "split", 1, 6, 2, 1'b0, 0, 1'b0, 0);
        run_search(1, "split_rnd", 1, 6, 2, 1'b1, 1 + 2 * $urandom_range(0, 2), 1'b0, 0);
        run_search(2, "abort", 0, 24'h3FFFFF, 1, 1'b0, 0, 1'b1, 4);
        run_search(2, "abort_hit", 0, 24'h3FFFFF, 1, 1'b1, 4, 1'b1, 4);

        // Stray Checker_Finish while the init stage is running.
        stray[0] = 1'b1;
        n0 = got_len(0);
        a0 = acks_w[0];
        pulse_start(0);
        n = 0;
        while (!start_w[0][0] && n < 100) begin @(negedge clk); n++; end
        check("stray_init", 32'(start_w[0]), 32'd1);
        check("stray_ack", 32'(ack_w[0]), 32'd0);
        @(negedge clk);
        check("stray_hold", 32'(start_w[0]), 32'd1);
        check("stray_sel", 32'(sel_w[0]), 32'd0);
        n = 0;
        while (start_w[0][0] && n < 100) begin @(negedge clk); n++; end
        stray[0] = 1'b0;
        wait_done(0, "stray_done");
        exp_keys = '{0, 1, 2, 3};
        check_result(0, "stray", 2, 3, n0, a0);
        clear_core(0, "stray");

        // Reset in the middle of the shuffle stage.
        pulse_start(0);
        n = 0;
        while (!start_w[0][1] && n < 100) begin @(negedge clk); n++; end
        check("mid_shuf", 32'(start_w[0][1]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_start", 32'(start_w[0]), 32'd0);
        check("mid_rst_busy", 32'(busy_w[0]), 32'd0);
        check("mid_rst_key", 32'(key_w[0]), 32'd0);
        check("mid_rst_ack", 32'(ack_w[0]), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        n0 = got_len(0);
        a0 = acks_w[0];
        repeat (20) @(negedge clk);
        check("idle_busy", 32'(busy_w[0]), 32'd0);
        check("idle_start", 32'(start_w[0]), 32'd0);
        check("idle_keys", got_len(0) - n0, 32'd0);
        check("idle_acks", acks_w[0] - a0, 32'd0);
        run_search(0, "post_rst", 0, 3, 1, 1'b0, 0, 1'b0, 0);

        for (int i = 0; i < 3; i++) check("handshake", viol_w[i], 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
